// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N decoder family.
package decoder_pkg;

   // Controller states.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   // Values of the mode input.
   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Widest select the one-hot helper supports; callers cast the result down to 2^N bits.
   localparam int unsigned ONE_HOT_MAX_N = 8;
   localparam int unsigned ONE_HOT_MAX_W = 1 << ONE_HOT_MAX_N;

   // One-hot encode sel for an n-bit select; an out-of-range sel yields all zero.
   function automatic logic [ONE_HOT_MAX_W-1:0] one_hot(
      input int unsigned              n,
      input logic [ONE_HOT_MAX_N-1:0] sel
   );
      logic [ONE_HOT_MAX_W-1:0] res;
      res = '0;
      if (32'(sel) < (32'd1 << n)) begin
         res[sel] = 1'b1;
      end
      return res;
   endfunction

endpackage : decoder_pkg

// File: rtl/decoder_dwell_timer.sv
// Dwell down-counter for scan mode: pulses step on the cycle the count reads zero,
// then reloads from the dwell value presented at that moment.
module decoder_dwell_timer #(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               load,
   input  logic               run,
   input  logic [DWELL_W-1:0] dwell,
   output logic               step
);

   logic [DWELL_W-1:0] cnt_q;
   logic [DWELL_W-1:0] cnt_d;

   // A step happens only while counting, never on the load cycle itself.
   assign step = run & ~load & ~clear & (cnt_q == '0);

   // Next count: clear beats load, load beats counting; a step reloads.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load || step) begin
         cnt_d = dwell;
      end else if (run) begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : decoder_dwell_timer

// File: rtl/decoder_nx2n_scan.sv
// Registered binary-to-one-hot decoder with a handshaked direct mode and a
// self-running scan mode that walks the one-hot bit with a programmable dwell.
// N must not exceed decoder_pkg::ONE_HOT_MAX_N.
//
// Handshake: a select is accepted on a rising edge where in_valid & in_ready;
// in_ready depends only on rst_n, en and mode, never on in_valid or FSM state.
module decoder_nx2n_scan
   import decoder_pkg::*;
#(
   parameter int unsigned N       = 3,
   parameter int unsigned DWELL_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N-1:0]         in_sel,
   input  logic [DWELL_W-1:0]   dwell,
   output logic [(1<<N)-1:0]    out,
   output logic                 out_valid,
   output logic [N-1:0]         idx,
   output logic                 wrap,
   output state_t               dbg_state
);

   localparam int unsigned OUT_W = 1 << N;

   state_t             state_q, state_d;
   logic [OUT_W-1:0]   out_q, out_d;
   logic               out_valid_q, out_valid_d;
   logic [N-1:0]       idx_q, idx_d;
   logic               wrap_q, wrap_d;

   logic               accept;
   logic               tmr_clear;
   logic               tmr_load;
   logic               tmr_run;
   logic               tmr_step;
   logic [N-1:0]       idx_inc;

   // Ready is a pure function of reset, enable and mode.
   assign in_ready = rst_n & en & (mode == MODE_DIRECT);
   assign accept   = in_valid & in_ready;

   // Timer controls: cleared while disabled, loaded on scan entry, counting while scanning.
   assign tmr_clear = ~en;
   assign tmr_load  = en & (mode == MODE_SCAN) & (state_q != ST_SCAN);
   assign tmr_run   = en & (mode == MODE_SCAN) & (state_q == ST_SCAN);

   assign idx_inc = idx_q + N'(1);

   decoder_dwell_timer #(
      .DWELL_W (DWELL_W)
   ) u_dwell_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (tmr_clear),
      .load  (tmr_load),
      .run   (tmr_run),
      .dwell (dwell),
      .step  (tmr_step)
   );

   // Next state and next output values; en and mode are re-evaluated every cycle.
   always_comb begin
      state_d     = state_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      idx_d       = idx_q;
      wrap_d      = 1'b0;
      if (!en) begin
         state_d     = ST_IDLE;
         out_d       = '0;
         out_valid_d = 1'b0;
         idx_d       = '0;
      end else if (mode == MODE_SCAN) begin
         state_d = ST_SCAN;
         if (state_q != ST_SCAN) begin
            // Entry always starts at position 0 and never flags a wrap.
            idx_d       = '0;
            out_d       = OUT_W'(1);
            out_valid_d = 1'b1;
         end else if (tmr_step) begin
            idx_d       = idx_inc;
            out_d       = OUT_W'(one_hot(N, ONE_HOT_MAX_N'(idx_inc)));
            out_valid_d = 1'b1;
            wrap_d      = (idx_q == {N{1'b1}});
         end
      end else begin
         state_d = ST_DIRECT;
         if (state_q != ST_DIRECT) begin
            // Nothing decoded yet in this mode; an entry-cycle accept overrides below.
            out_d       = '0;
            out_valid_d = 1'b0;
            idx_d       = '0;
         end
         if (accept) begin
            out_d       = OUT_W'(one_hot(N, ONE_HOT_MAX_N'(in_sel)));
            idx_d       = in_sel;
            out_valid_d = 1'b1;
         end
      end
   end

   // FSM and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         wrap_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         idx_q       <= idx_d;
         wrap_q      <= wrap_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign idx       = idx_q;
   assign wrap      = wrap_q;
   assign dbg_state = state_q;

endmodule : decoder_nx2n_scan

// File: tb/tb_decoder_nx2n_scan.sv
// Directed bench for decoder_nx2n_scan with N=3, DWELL_W=8.
module tb_decoder_nx2n_scan;
   import decoder_pkg::*;

   localparam int unsigned N       = 3;
   localparam int unsigned DWELL_W = 8;
   localparam int unsigned OUT_W   = 1 << N;

   // Clock and stimulus signals.
   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               mode;
   logic               in_valid;
   logic               in_ready;
   logic [N-1:0]       in_sel;
   logic [DWELL_W-1:0] dwell;
   logic [OUT_W-1:0]   out;
   logic               out_valid;
   logic [N-1:0]       idx;
   logic               wrap;
   state_t             dbg_state;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decoder_nx2n_scan #(
      .N       (N),
      .DWELL_W (DWELL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sel    (in_sel),
      .dwell     (dwell),
      .out       (out),
      .out_valid (out_valid),
      .idx       (idx),
      .wrap      (wrap),
      .dbg_state (dbg_state)
   );

   // Advance one clock and settle 1 ns past the edge before sampling or driving.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [OUT_W-1:0] e_out, input logic e_valid,
                          input logic [N-1:0] e_idx, input logic e_wrap);
      chk({tag, ".out"}, 32'(out), 32'(e_out));
      chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
      chk({tag, ".idx"}, 32'(idx), 32'(e_idx));
      chk({tag, ".wrap"}, 32'(wrap), 32'(e_wrap));
   endtask

   initial begin
      int exp_i;
      int wraps;
      bit found;

      // Reset held for two edges.
      rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; in_sel = '0; dwell = '0;
      tick(); tick();
      chk_out("reset", 8'h00, 1'b0, 3'd0, 1'b0);
      chk("reset.in_ready", 32'(in_ready), 32'd0);
      chk("reset.state", 32'(dbg_state), 32'(ST_IDLE));

      // Direct mode: select 5 accepted on the entry cycle, then held.
      rst_n = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b1; in_sel = 3'd5;
      #1;
      chk("direct.in_ready", 32'(in_ready), 32'd1);
      tick();
      chk_out("direct5", 8'b0010_0000, 1'b1, 3'd5, 1'b0);
      chk("direct5.state", 32'(dbg_state), 32'(ST_DIRECT));
      in_valid = 1'b0; in_sel = 3'd2;
      tick(); tick();
      chk_out("direct5_hold", 8'b0010_0000, 1'b1, 3'd5, 1'b0);

      // Back-to-back selects 0, 7, 3.
      in_valid = 1'b1; in_sel = 3'd0;
      tick();
      chk_out("b2b0", 8'h01, 1'b1, 3'd0, 1'b0);
      chk("b2b0.in_ready", 32'(in_ready), 32'd1);
      in_sel = 3'd7;
      tick();
      chk_out("b2b7", 8'h80, 1'b1, 3'd7, 1'b0);
      chk("b2b7.in_ready", 32'(in_ready), 32'd1);
      in_sel = 3'd3;
      tick();
      chk_out("b2b3", 8'h08, 1'b1, 3'd3, 1'b0);
      chk("b2b3.in_ready", 32'(in_ready), 32'd1);

      // Scan with dwell=2: each position held 3 cycles, wrap 24 cycles after entry.
      mode = 1'b1; dwell = 8'd2; in_valid = 1'b1; in_sel = 3'd6;
      #1;
      chk("scan.in_ready", 32'(in_ready), 32'd0);
      wraps = 0;
      for (int e = 0; e < 26; e++) begin
         tick();
         exp_i = (e < 24) ? (e / 3) : 0;
         chk_out($sformatf("scan_d2_e%0d", e), 8'(8'd1 << exp_i), 1'b1, 3'(exp_i), (e == 24));
         chk($sformatf("scan_d2_e%0d.in_ready", e), 32'(in_ready), 32'd0);
         if (wrap) wraps++;
      end
      chk("scan_d2.wrap_count", 32'(wraps), 32'd1);
      chk("scan_d2.state", 32'(dbg_state), 32'(ST_SCAN));
      in_valid = 1'b0;

      // Disable, then scan with dwell=0: one step per cycle, period 8.
      en = 1'b0;
      tick();
      chk_out("disable", 8'h00, 1'b0, 3'd0, 1'b0);
      chk("disable.state", 32'(dbg_state), 32'(ST_IDLE));
      en = 1'b1; dwell = 8'd0;
      tick();
      chk_out("scan_d0_entry", 8'h01, 1'b1, 3'd0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk_out($sformatf("scan_d0_k%0d", k), 8'(8'd1 << (k % 8)), 1'b1, 3'(k % 8), (k == 8));
      end

      // Dwell raised to 4: the next reload makes position 1 last 5 cycles.
      dwell = 8'd4;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_out($sformatf("scan_d4_k%0d", k), 8'h02, 1'b1, 3'd1, 1'b0);
      end
      tick();
      chk_out("scan_d4_next", 8'h04, 1'b1, 3'd2, 1'b0);

      // Run on to idx=6 (bounded), then drop en.
      dwell = 8'd0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (idx === 3'd6) found = 1'b1;
         else tick();
      end
      chk("scan_reach_idx6", 32'(found), 32'd1);
      en = 1'b0;
      tick();
      chk_out("scan_en_drop", 8'h00, 1'b0, 3'd0, 1'b0);
      en = 1'b1; mode = 1'b1;
      tick();
      chk_out("scan_restart", 8'h01, 1'b1, 3'd0, 1'b0);

      // Scan to direct with in_valid high: accepted on the entry cycle.
      mode = 1'b0; in_valid = 1'b1; in_sel = 3'd4;
      tick();
      chk_out("direct4", 8'h10, 1'b1, 3'd4, 1'b0);

      // Reset during direct output; the concurrent in_valid is not accepted.
      rst_n = 1'b0; in_sel = 3'd6;
      #1;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      tick();
      chk_out("rst_mid", 8'h00, 1'b0, 3'd0, 1'b0);
      chk("rst_mid.state", 32'(dbg_state), 32'(ST_IDLE));
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      chk_out("post_rst_entry", 8'h00, 1'b0, 3'd0, 1'b0);
      in_valid = 1'b1; in_sel = 3'd1;
      tick();
      chk_out("post_rst_sel1", 8'h02, 1'b1, 3'd1, 1'b0);
      in_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_decoder_nx2n_scan

// File: doc/decoder_nx2n_scan.md
# decoder_nx2n_scan

Parametrised, registered binary-to-one-hot decoder with an N-bit select and 2^N outputs, the sequential successor to our fixed 3-to-8 combinational decoder. It has two modes. Direct mode decodes a select accepted over a valid/ready handshake. Scan mode walks the one-hot output through every position with a programmable dwell time. It drives chip-select, row-select and LED/mux scan lines.

## Interface
- `N`, default 3: select width; output width is 2^N.
- `DWELL_W`, default 8: width of the dwell-count input.
- `clk`, input, 1: the single clock; all logic is on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `en`, input, 1: block enable; low forces outputs to zero.
- `mode`, input, 1: 0 selects direct mode, 1 selects scan mode.
- `in_valid`, input, 1: `in_sel` is valid.
- `in_ready`, output, 1: the block accepts `in_sel`.
- `in_sel`, input, N: binary select for direct mode.
- `dwell`, input, DWELL_W: scan mode holds each position for dwell+1 cycles.
- `out`, output, 2^N: registered one-hot output, or all zero.
- `out_valid`, output, 1: `out` holds a valid one-hot value.
- `idx`, output, N: binary index of the active bit in `out`.
- `wrap`, output, 1: one-cycle pulse when scan moves from index 2^N-1 to index 0.

## Operation
- FSM states are IDLE, DIRECT and SCAN. Reset enters IDLE.
- Transitions are evaluated every cycle, highest priority first:
  - `en`=0 → IDLE.
  - `en`=1 and `mode`=1 → SCAN.
  - `en`=1 and `mode`=0 → DIRECT.
- `in_ready` = `rst_n` & `en` & ~`mode`. It is combinational and does not depend on FSM state.
- A handshake is accepted when `in_valid` & `in_ready`.
- IDLE:
  - `out`=0, `out_valid`=0, `idx`=0, `wrap`=0.
  - The dwell counter is cleared.
- DIRECT:
  - On an accepted handshake, the next cycle gives `out`=1<<`in_sel`, `idx`=`in_sel`, `out_valid`=1.
  - Without a handshake, `out`, `idx` and `out_valid` hold their values.
  - On entry from IDLE or SCAN, `out`=0 and `out_valid`=0 until the first handshake is accepted.
  - The handshake is accepted in the same cycle as entry if `in_valid` is high.
- SCAN:
  - On entry, `idx`=0, `out`=1, `out_valid`=1. The dwell counter loads `dwell`.
  - Each cycle the dwell counter decrements. On the cycle it reads 0, `idx` increments modulo 2^N and the counter reloads from the current `dwell`.
  - `dwell` is sampled at each reload, so a change takes effect at the next step.
  - `wrap`=1 for exactly the one cycle in which `idx` changes from 2^N-1 to 0.
  - `in_valid` is ignored because `in_ready`=0.
- `out` is always 0 or exactly one-hot.
- `out` and `idx` are consistent in every cycle: `out`=1<<`idx` whenever `out_valid`=1.

## Timing
- Reset (`rst_n`=0 sampled at a clock edge) sets state=IDLE, `out`=0, `out_valid`=0, `idx`=0, `wrap`=0 and dwell counter=0 at that edge.
- Reset in the middle of a scan or a handshake aborts it. Nothing is retained.
- Direct-mode latency is 1 cycle from the accept edge to `out`.
- Throughput is one select per cycle.
- `en` falling: the next edge gives `out`=0 and `out_valid`=0.
- Mode switch: the new mode's entry behaviour appears at the next edge.
- Scan period is 2^N·(`dwell`+1) cycles. With `dwell`=0, `idx` advances every cycle.
- `wrap` is registered and aligned with the cycle in which `idx` first reads 0 after 2^N-1.
- The first entry into SCAN does not assert `wrap`.

## Structure
- Shared package `decoder_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_DIRECT`, `ST_SCAN`);
  - the mode constants `MODE_DIRECT`=0 and `MODE_SCAN`=1;
  - a one-hot function parametrised by N.
- Sub-module `decoder_dwell_timer`, parameter DWELL_W:
  - inputs: `load`, `dwell`;
  - output: `step`, a pulse when the count reaches 0;
  - the top level owns the FSM, `idx` and the output registers.

## Test plan
All scenarios use N=3, DWELL_W=8.
- Reset, then `en`=1, `mode`=0, `in_valid`=1 with `in_sel`=5 → the next cycle gives `out`=8'b0010_0000, `idx`=5, `out_valid`=1. `in_valid` then drops → the values hold.
- Back-to-back selects 0, 7, 3 on consecutive cycles → `out` = 8'h01, 8'h80, 8'h08 on consecutive cycles. `in_ready` stays 1 throughout.
- `mode`=1 with `dwell`=2 → `out` walks 8'h01, 8'h02 … 8'h80, each value held for 3 cycles. `wrap` pulses once, 24 cycles after entry, as `idx` returns to 0. `in_ready`=0 throughout.
- Scan with `dwell`=0 → `idx` advances every cycle with an 8-cycle period. `dwell` changed to 4 mid-scan → the step after the next reload holds for 5 cycles.
- `en` dropped in mid-scan at `idx`=6 → the next cycle gives `out`=0, `out_valid`=0, `idx`=0. `en` raised again with `mode`=1 → the scan restarts at `idx`=0 with `wrap`=0.
- `rst_n`=0 for one cycle during direct-mode output 8'h10 → all outputs are 0 at the next edge. Simultaneous `in_valid`=1 is not accepted.
